led_pwm_multi: RTL



---
 rtl/led_pwm_pkg.sv | 21 ++
 rtl/led_pwm_multi_pulse_div.sv | 24 ++
 rtl/led_pwm_multi.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the multi-channel LED PWM driver.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_t;

    // Blink half-period in clock cycles.
    function automatic int half_cycles(input int clk_hz, input int tick_hz);
        return clk_hz / (2 * tick_hz);
    endfunction

    // Width of the channel select field; at least one bit.
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_multi_pulse_div.sv
// pulse_div: free-running divide-by-N counter. hit_o is high during the
// last count (cnt == N-1), so it is a one-cycle pulse every N cycles.
// With N == 1 the pulse is permanently high.
module pulse_div #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_n,
    output logic hit_o
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;

    // Count 0..N-1 and wrap.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)              cnt_q <= '0;
        else if (cnt_q == LAST)  cnt_q <= '0;
        else                     cnt_q <= cnt_q + 1'b1;
    end

    assign hit_o = (cnt_q == LAST);
endmodule

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: CH-channel LED driver (off / on / blink / PWM).
// Config writes land in per-channel shadow registers and are promoted to
// the active set at the PWM period boundary, so a channel never changes
// mode or duty mid-period.
// Optional build macro LED_PWM_BREATHE_EN: mode 10 becomes a triangle
// "breathe" dimming driven by a shared level that moves one step per
// PWM period instead of the square-wave blink.
module led_pwm_multi
    import led_pwm_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int CH      = 4,
    parameter int DW      = 8,
    parameter int PRESC   = 195
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [ch_width(CH)-1:0]   cfg_ch_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [DW-1:0]             cfg_duty_i,
    output logic [CH-1:0]             led_o,
    output logic                      tick_o,
    output logic                      pwm_wrap_o
);
    localparam int              HALF   = half_cycles(CLK_HZ, TICK_HZ);
    localparam int              CW     = ch_width(CH);
    localparam logic [CW:0]     CH_LIM = (CW + 1)'(CH);
    localparam logic [DW-1:0]   WMAX   = '1;

    logic            b_hit, step, boundary;
    logic            tick_q, wrap_q, blink_val;
    logic [DW-1:0]   wcnt_q;
    logic [CH-1:0]   pend_q, led_q;
    logic            ch_ok, xfer;
    led_mode_t       act_mode_q [CH];
    led_mode_t       shd_mode_q [CH];
    logic [DW-1:0]   act_duty_q [CH];
    logic [DW-1:0]   shd_duty_q [CH];

    pulse_div #(.N(HALF))  u_blink_div (.clk_i(clk_i), .rst_n(rst_n), .hit_o(b_hit));
    pulse_div #(.N(PRESC)) u_presc     (.clk_i(clk_i), .rst_n(rst_n), .hit_o(step));

    assign boundary = step && (wcnt_q == WMAX);

    // Tick pulse registered from the blink divider's last count.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= b_hit;
    end

    // PWM step counter and registered period-boundary pulse.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            if (step) wcnt_q <= wcnt_q + 1'b1;
            wrap_q <= boundary;
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [DW-1:0] lvl_q;
    logic          up_q;

    // Triangle level: 0 -> max -> 0, one step per PWM period.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
            up_q  <= 1'b1;
        end else if (boundary) begin
            if (up_q) begin
                if (lvl_q == WMAX) begin
                    lvl_q <= lvl_q - 1'b1;
                    up_q  <= 1'b0;
                end else begin
                    lvl_q <= lvl_q + 1'b1;
                end
            end else begin
                if (lvl_q == '0) begin
                    lvl_q <= lvl_q + 1'b1;
                    up_q  <= 1'b1;
                end else begin
                    lvl_q <= lvl_q - 1'b1;
                end
            end
        end
    end

    assign blink_val = (wcnt_q < lvl_q);
`else
    logic blink_q;

    // Square-wave blink state, toggled on each divider wrap.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)     blink_q <= 1'b0;
        else if (b_hit) blink_q <= ~blink_q;
    end

    assign blink_val = blink_q;
`endif

    // Out-of-range channels always look ready and their writes are dropped.
    assign ch_ok       = ({1'b0, cfg_ch_i} < CH_LIM);
    assign cfg_ready_o = ch_ok ? !pend_q[cfg_ch_i] : 1'b1;
    assign xfer        = cfg_valid_i && cfg_ready_o && ch_ok;

    // Shadow capture on transfer; shadow -> active promotion on boundary.
    // A channel accepting a write is never pending, so promotion and capture
    // of the same channel cannot collide; a write on the boundary cycle
    // stays pending until the next boundary.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int i = 0; i < CH; i++) begin
                act_mode_q[i] <= MODE_OFF;
                shd_mode_q[i] <= MODE_OFF;
                act_duty_q[i] <= '0;
                shd_duty_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (boundary && pend_q[i]) begin
                    act_mode_q[i] <= shd_mode_q[i];
                    act_duty_q[i] <= shd_duty_q[i];
                    pend_q[i]     <= 1'b0;
                end
                if (xfer && (CW'(i) == cfg_ch_i)) begin
                    shd_mode_q[i] <= led_mode_t'(cfg_mode_i);
                    shd_duty_q[i] <= cfg_duty_i;
                    pend_q[i]     <= 1'b1;
                end
            end
        end
    end

    // Registered per-channel LED drive from the current counter state.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                case (act_mode_q[i])
                    MODE_OFF:   led_q[i] <= 1'b0;
                    MODE_ON:    led_q[i] <= 1'b1;
                    MODE_BLINK: led_q[i] <= blink_val;
                    MODE_PWM:   led_q[i] <= (wcnt_q < act_duty_q[i]);
                    default:    led_q[i] <= 1'b0;
                endcase
            end
        end
    end

    assign led_o      = led_q;
    assign tick_o     = tick_q;
    assign pwm_wrap_o = wrap_q;
endmodule
